// File: rtl/control_unit_p.sv
// control_unit_p -- multicycle control unit for a small load/store processor.
// Sequences FETCH -> DECODE -> execute, drives register file, ALU and data
// memory controls as registered Moore outputs derived from State and IR_Out.
// Optional feature: define CU_JPZ_EN to build in the JPZ (jump if zero)
// instruction, opcode 4'b0110, and its FSM state 4'hA.  Without the macro,
// opcode 0110 executes as NOOP and the PC only increments or resets.
module control_unit_p #(
  parameter int PC_W     = 7,
  parameter int IR_W     = 16,
  parameter int D_ADDR_W = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [IR_W-1:0]     InstrData,
  input  logic                RF_Rp_zero,
  output logic [PC_W-1:0]     PC_Out,
  output logic [IR_W-1:0]     IR_Out,
  output logic [3:0]          State,
  output logic [3:0]          NextState,
  output logic [D_ADDR_W-1:0] D_Addr,
  output logic                D_Wr,
  output logic                RF_s,
  output logic                RF_W_en,
  output logic [3:0]          RF_W_addr,
  output logic [3:0]          RF_Ra_addr,
  output logic [3:0]          RF_Rb_addr,
  output logic [2:0]          ALU_s0,
  output logic                Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'h0,
    S_FETCH  = 4'h1,
    S_DECODE = 4'h2,
    S_NOOP   = 4'h3,
    S_LOAD_A = 4'h4,
    S_LOAD_B = 4'h5,
    S_STORE  = 4'h6,
    S_ADD    = 4'h7,
    S_SUB    = 4'h8,
`ifdef CU_JPZ_EN
    S_HALT   = 4'h9,
    S_JPZ    = 4'hA
`else
    S_HALT   = 4'h9
`endif
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;
`ifdef CU_JPZ_EN
  localparam logic [3:0] OP_JPZ   = 4'b0110;
`endif

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t state;
  state_t next_state;

  logic d_wr_q;
  logic rf_w_en_q;

  // Instruction fields; only the low 16 bits of the IR carry meaning.
  logic [3:0]          op;
  logic [3:0]          rn;
  logic [3:0]          ra;
  logic [3:0]          rb;
  logic [D_ADDR_W-1:0] addr;

  assign op   = IR_Out[15:12];
  assign rn   = IR_Out[11:8];
  assign ra   = IR_Out[7:4];
  assign rb   = IR_Out[3:0];
  assign addr = D_ADDR_W'(IR_Out[7:0]);

`ifdef CU_JPZ_EN
  // The offset is relative to the JPZ instruction itself, but PC_Out has
  // already advanced past it during FETCH, hence the extra minus one.
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] jump_target;

  assign off_ext     = PC_W'($signed(IR_Out[7:0]));
  assign jump_target = PC_Out + off_ext - PC_ONE;
`else
  logic unused_rp_zero;

  assign unused_rp_zero = RF_Rp_zero;
`endif

  assign State     = state;
  assign NextState = next_state;

  // Write strobes are forced low the moment Reset rises so that no memory
  // or register write can slip out during the cycle that reset is held.
  assign D_Wr    = d_wr_q & ~Reset;
  assign RF_W_en = rf_w_en_q & ~Reset;

  // Next-state decode; Reset forces INIT so NextState reflects the reset edge.
  always_comb begin
    next_state = S_INIT;
    if (!Reset) begin
      case (state)
        S_INIT:   next_state = S_FETCH;
        S_FETCH:  next_state = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_NOOP:  next_state = S_NOOP;
            OP_STORE: next_state = S_STORE;
            OP_LOAD:  next_state = S_LOAD_A;
            OP_ADD:   next_state = S_ADD;
            OP_SUB:   next_state = S_SUB;
            OP_HALT:  next_state = S_HALT;
`ifdef CU_JPZ_EN
            OP_JPZ:   next_state = S_JPZ;
`endif
            default:  next_state = S_NOOP;
          endcase
        end
        S_NOOP:   next_state = S_FETCH;
        S_STORE:  next_state = S_FETCH;
        S_ADD:    next_state = S_FETCH;
        S_SUB:    next_state = S_FETCH;
        S_LOAD_A: next_state = S_LOAD_B;
        S_LOAD_B: next_state = S_FETCH;
`ifdef CU_JPZ_EN
        S_JPZ:    next_state = S_FETCH;
`endif
        S_HALT:   next_state = S_HALT;
        default:  next_state = S_INIT;
      endcase
    end
  end

  // State, PC, IR and the registered control outputs; outputs are computed
  // for the state being entered so they line up with State each cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_INIT;
      PC_Out     <= '0;
      IR_Out     <= '0;
      D_Addr     <= '0;
      d_wr_q     <= 1'b0;
      RF_s       <= 1'b0;
      rf_w_en_q  <= 1'b0;
      RF_W_addr  <= '0;
      RF_Ra_addr <= '0;
      RF_Rb_addr <= '0;
      ALU_s0     <= ALU_PASS;
      Halted     <= 1'b0;
    end else begin
      state <= next_state;

      if (state == S_FETCH) begin
        IR_Out <= InstrData;
        PC_Out <= PC_Out + PC_ONE;
      end
`ifdef CU_JPZ_EN
      if ((state == S_JPZ) && RF_Rp_zero) begin
        PC_Out <= jump_target;
      end
`endif

      D_Addr     <= '0;
      d_wr_q     <= 1'b0;
      RF_s       <= 1'b0;
      rf_w_en_q  <= 1'b0;
      RF_W_addr  <= '0;
      RF_Ra_addr <= '0;
      RF_Rb_addr <= '0;
      ALU_s0     <= ALU_PASS;
      Halted     <= 1'b0;

      case (next_state)
        S_STORE: begin
          D_Addr     <= addr;
          RF_Ra_addr <= rn;
          d_wr_q     <= 1'b1;
        end
        S_LOAD_A: begin
          D_Addr <= addr;
        end
        S_LOAD_B: begin
          D_Addr    <= addr;
          RF_s      <= 1'b1;
          RF_W_addr <= rn;
          rf_w_en_q <= 1'b1;
        end
        S_ADD: begin
          RF_Ra_addr <= ra;
          RF_Rb_addr <= rb;
          RF_W_addr  <= rn;
          rf_w_en_q  <= 1'b1;
          ALU_s0     <= ALU_ADD;
        end
        S_SUB: begin
          RF_Ra_addr <= ra;
          RF_Rb_addr <= rb;
          RF_W_addr  <= rn;
          rf_w_en_q  <= 1'b1;
          ALU_s0     <= ALU_SUB;
        end
`ifdef CU_JPZ_EN
        S_JPZ: begin
          RF_Ra_addr <= rn;
        end
`endif
        S_HALT: begin
          Halted <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_p.sv
// tb_control_unit_p -- scoreboard bench for control_unit_p (default widths).
// Instruction memory is modelled as an array read combinationally at PC_Out.
// JPZ scenarios follow the CU_JPZ_EN macro, matching the build of the design.
module tb_control_unit_p;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] InstrData;
  logic        RF_Rp_zero;
  logic [6:0]  PC_Out;
  logic [15:0] IR_Out;
  logic [3:0]  State;
  logic [3:0]  NextState;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic        Halted;

  logic [15:0] imem [0:127];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic       dwr;
    logic       wen;
    logic       rfs;
    logic       halt;
    logic [7:0] daddr;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } vec_t;

  vec_t sb[$];

  control_unit_p #(.PC_W(7), .IR_W(16), .D_ADDR_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .InstrData(InstrData), .RF_Rp_zero(RF_Rp_zero),
    .PC_Out(PC_Out), .IR_Out(IR_Out), .State(State), .NextState(NextState),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .Halted(Halted)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clk = ~Clk;

  // Instruction memory responds combinationally to the PC.
  assign InstrData = imem[PC_Out];

  function automatic vec_t mk(input logic [3:0] st, input logic [6:0] pc);
    vec_t v;
    v    = '0;
    v.st = st;
    v.pc = pc;
    return v;
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v.st    = State;
    v.pc    = PC_Out;
    v.dwr   = D_Wr;
    v.wen   = RF_W_en;
    v.rfs   = RF_s;
    v.halt  = Halted;
    v.daddr = D_Addr;
    v.wa    = RF_W_addr;
    v.ra    = RF_Ra_addr;
    v.rb    = RF_Rb_addr;
    v.alu   = ALU_s0;
    return v;
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e, got;
    clear_imem();
    RF_Rp_zero = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    sb.push_back(mk(4'h0, 7'h00));
    e = sb.pop_front();
    got = sample();
    total++;
    if (got !== e) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", got, e);
    end
    total++;
    if (IR_Out !== 16'h0000 || NextState !== 4'h0) begin
      bad++;
      $display("[TB] FAIL reset_ir_next got IR=%h NS=%h exp IR=0000 NS=0", IR_Out, NextState);
    end
    Reset = 1'b0;
    #1;
    total++;
    if (NextState !== 4'h1) begin
      bad++;
      $display("[TB] FAIL init_next got=%h exp=1", NextState);
    end
  endtask

  task automatic test_load();
    vec_t e, got;
    int n = 0;
    clear_imem();
    imem[0] = 16'h2105;
    do_reset();
    sb.push_back(mk(4'h1, 7'h00));
    sb.push_back(mk(4'h2, 7'h01));
    e = mk(4'h4, 7'h01); e.daddr = 8'h05; sb.push_back(e);
    e = mk(4'h5, 7'h01); e.daddr = 8'h05; e.rfs = 1'b1; e.wen = 1'b1; e.wa = 4'h1; sb.push_back(e);
    sb.push_back(mk(4'h1, 7'h01));
    while (sb.size() > 0) begin
      @(posedge Clk); #1;
      e = sb.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("[TB] FAIL load cyc=%0d got=%h exp=%h", n, got, e);
      end
      n++;
    end
    total++;
    if (IR_Out !== 16'h2105) begin
      bad++;
      $display("[TB] FAIL load_ir got=%h exp=2105", IR_Out);
    end
  endtask

  task automatic test_back_to_back();
    vec_t e, got;
    int n = 0;
    clear_imem();
    imem[0] = 16'h3312;
    imem[1] = 16'h4312;
    imem[2] = 16'h1407;
    do_reset();
    sb.push_back(mk(4'h1, 7'h00));
    sb.push_back(mk(4'h2, 7'h01));
    e = mk(4'h7, 7'h01); e.alu = 3'b001; e.ra = 4'h1; e.rb = 4'h2; e.wa = 4'h3; e.wen = 1'b1; sb.push_back(e);
    sb.push_back(mk(4'h1, 7'h01));
    sb.push_back(mk(4'h2, 7'h02));
    e = mk(4'h8, 7'h02); e.alu = 3'b010; e.ra = 4'h1; e.rb = 4'h2; e.wa = 4'h3; e.wen = 1'b1; sb.push_back(e);
    sb.push_back(mk(4'h1, 7'h02));
    sb.push_back(mk(4'h2, 7'h03));
    e = mk(4'h6, 7'h03); e.dwr = 1'b1; e.daddr = 8'h07; e.ra = 4'h4; sb.push_back(e);
    sb.push_back(mk(4'h1, 7'h03));
    sb.push_back(mk(4'h2, 7'h04));
    sb.push_back(mk(4'h3, 7'h04));
    sb.push_back(mk(4'h1, 7'h04));
    while (sb.size() > 0) begin
      @(posedge Clk); #1;
      e = sb.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("[TB] FAIL alu_store cyc=%0d got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_jpz();
    vec_t e, got;
    int n = 0;
`ifdef CU_JPZ_EN
    for (int run = 0; run < 2; run++) begin
      clear_imem();
      imem[10] = 16'h62FC;
      RF_Rp_zero = (run == 0);
      do_reset();
      for (int i = 0; i < 10; i++) begin
        sb.push_back(mk(4'h1, 7'(i)));
        sb.push_back(mk(4'h2, 7'(i + 1)));
        sb.push_back(mk(4'h3, 7'(i + 1)));
      end
      sb.push_back(mk(4'h1, 7'd10));
      sb.push_back(mk(4'h2, 7'd11));
      e = mk(4'hA, 7'd11); e.ra = 4'h2; sb.push_back(e);
      sb.push_back(mk(4'h1, (run == 0) ? 7'd6 : 7'd11));
      while (sb.size() > 0) begin
        @(posedge Clk); #1;
        e = sb.pop_front();
        got = sample();
        total++;
        if (got !== e) begin
          bad++;
          $display("[TB] FAIL jpz run=%0d cyc=%0d got=%h exp=%h", run, n, got, e);
        end
        n++;
      end
    end
`else
    clear_imem();
    imem[0] = 16'h62FC;
    RF_Rp_zero = 1'b1;
    do_reset();
    sb.push_back(mk(4'h1, 7'h00));
    sb.push_back(mk(4'h2, 7'h01));
    sb.push_back(mk(4'h3, 7'h01));
    sb.push_back(mk(4'h1, 7'h01));
    while (sb.size() > 0) begin
      @(posedge Clk); #1;
      e = sb.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("[TB] FAIL op6_as_noop cyc=%0d got=%h exp=%h", n, got, e);
      end
      n++;
    end
`endif
    RF_Rp_zero = 1'b0;
  endtask

  task automatic test_halt();
    vec_t e, got;
    int n = 0;
    clear_imem();
    imem[1] = 16'h5000;
    do_reset();
    sb.push_back(mk(4'h1, 7'h00));
    sb.push_back(mk(4'h2, 7'h01));
    sb.push_back(mk(4'h3, 7'h01));
    sb.push_back(mk(4'h1, 7'h01));
    sb.push_back(mk(4'h2, 7'h02));
    for (int i = 0; i < 12; i++) begin
      e = mk(4'h9, 7'h02); e.halt = 1'b1; sb.push_back(e);
    end
    while (sb.size() > 0) begin
      @(posedge Clk); #1;
      e = sb.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("[TB] FAIL halt cyc=%0d got=%h exp=%h", n, got, e);
      end
      n++;
    end
    total++;
    if (IR_Out !== 16'h5000) begin
      bad++;
      $display("[TB] FAIL halt_ir got=%h exp=5000", IR_Out);
    end
    Reset = 1'b1;
    #1;
    total++;
    if (NextState !== 4'h0) begin
      bad++;
      $display("[TB] FAIL halt_reset_next got=%h exp=0", NextState);
    end
    @(posedge Clk); #1;
    e = mk(4'h0, 7'h00);
    got = sample();
    total++;
    if (got !== e || IR_Out !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL halt_exit got=%h ir=%h exp=%h ir=0000", got, IR_Out, e);
    end
    Reset = 1'b0;
  endtask

  task automatic test_reset_midload();
    vec_t e, got;
    int n = 0;
    clear_imem();
    imem[0] = 16'h2105;
    do_reset();
    sb.push_back(mk(4'h1, 7'h00));
    sb.push_back(mk(4'h2, 7'h01));
    e = mk(4'h4, 7'h01); e.daddr = 8'h05; sb.push_back(e);
    e = mk(4'h5, 7'h01); e.daddr = 8'h05; e.rfs = 1'b1; e.wen = 1'b1; e.wa = 4'h1; sb.push_back(e);
    while (sb.size() > 0) begin
      @(posedge Clk); #1;
      e = sb.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("[TB] FAIL midload cyc=%0d got=%h exp=%h", n, got, e);
      end
      n++;
    end
    Reset = 1'b1;
    #1;
    total++;
    if (RF_W_en !== 1'b0 || D_Wr !== 1'b0 || NextState !== 4'h0) begin
      bad++;
      $display("[TB] FAIL midload_strobe got wen=%b dwr=%b ns=%h exp wen=0 dwr=0 ns=0", RF_W_en, D_Wr, NextState);
    end
    @(posedge Clk); #1;
    e = mk(4'h0, 7'h00);
    got = sample();
    total++;
    if (got !== e) begin
      bad++;
      $display("[TB] FAIL midload_reset got=%h exp=%h", got, e);
    end
    Reset = 1'b0;
  endtask

  task automatic test_pc_wrap();
    vec_t e, got;
    int n = 0;
    logic [6:0] p;
    clear_imem();
    do_reset();
    p = 7'h00;
    for (int i = 0; i < 129; i++) begin
      sb.push_back(mk(4'h1, p));
      p = p + 7'h01;
      sb.push_back(mk(4'h2, p));
      sb.push_back(mk(4'h3, p));
    end
    while (sb.size() > 0) begin
      @(posedge Clk); #1;
      e = sb.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("[TB] FAIL pc_wrap cyc=%0d got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    Reset = 1'b1;
    RF_Rp_zero = 1'b0;
    clear_imem();
    test_reset();
    test_load();
    test_back_to_back();
    test_jpz();
    test_halt();
    test_reset_midload();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
